// File: rtl/pipe_ctrl_hazard.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_hazard
//  Brief    : 5-stage pipeline controller with hazard unit. Carries the
//             decoded control word D->E->M->W, generates forwarding selects,
//             load-use / branch-compare / MDU stalls, D/E flushes, and
//             sequences multi-cycle MULT/DIV operations.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_hazard #(
  parameter int CW      = 11,
  parameter int RW      = 5,
  parameter int MDU_LAT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] ctrlD,
  input  logic          branchD,
  input  logic          jumpD,
  input  logic          equalD,
  input  logic          mdu_startD,
  input  logic          mdu_readD,
  input  logic [RW-1:0] rsD,
  input  logic [RW-1:0] rtD,
  input  logic [RW-1:0] rsE,
  input  logic [RW-1:0] rtE,
  input  logic [RW-1:0] writeregE,
  input  logic [RW-1:0] writeregM,
  input  logic [RW-1:0] writeregW,
  output logic [CW-1:0] ctrlE,
  output logic [2:0]    ctrlM,
  output logic [1:0]    ctrlW,
  output logic          pcsrcD,
  output logic          stallF,
  output logic          stallD,
  output logic          flushD,
  output logic          flushE,
  output logic [1:0]    fwdAE,
  output logic [1:0]    fwdBE,
  output logic          fwdAD,
  output logic          fwdBD,
  output logic          mdu_busy,
  output logic          mdu_doneW
);

  // Counter width; kept at least 1 so the declaration stays legal when unused
  localparam int c_CNT_W = (MDU_LAT > 0) ? $clog2(MDU_LAT + 1) : 1;

  logic [CW-1:0] r_ctrlE;
  logic [2:0]    r_ctrlM;
  logic [1:0]    r_ctrlW;
  logic          r_mduDone;
  logic          w_mduBusy;
  logic          w_mduAccept;

  // Register-match terms; $0 is hardwired zero so it never creates a hazard
  logic w_eHitRsD, w_eHitRtD, w_mHitRsD, w_mHitRtD;
  logic w_mHitRsE, w_mHitRtE, w_wHitRsE, w_wHitRtE;
  logic w_lwStall, w_brStall, w_mduStall, w_stall;

  assign w_eHitRsD = (rsD != '0) && (writeregE == rsD);
  assign w_eHitRtD = (rtD != '0) && (writeregE == rtD);
  assign w_mHitRsD = (rsD != '0) && (writeregM == rsD);
  assign w_mHitRtD = (rtD != '0) && (writeregM == rtD);
  assign w_mHitRsE = (rsE != '0) && (writeregM == rsE);
  assign w_mHitRtE = (rtE != '0) && (writeregM == rtE);
  assign w_wHitRsE = (rsE != '0) && (writeregW == rsE);
  assign w_wHitRtE = (rtE != '0) && (writeregW == rtE);

  assign w_lwStall  = r_ctrlE[1] & r_ctrlE[0] & (w_eHitRsD | w_eHitRtD);
  assign w_brStall  = branchD & ((r_ctrlE[0] & (w_eHitRsD | w_eHitRtD)) |
                                 (r_ctrlM[1] & (w_mHitRsD | w_mHitRtD)));
  assign w_mduStall = w_mduBusy & (mdu_readD | mdu_startD);
  assign w_stall    = w_lwStall | w_brStall | w_mduStall;

  // A start held off by any stall is simply retried the following cycle
  assign w_mduAccept = mdu_startD & ~w_stall;

  assign stallF = w_stall;
  assign stallD = w_stall;
  assign flushE = w_stall;
  assign pcsrcD = branchD & equalD;
  // A stalled branch resolves later, so the redirect flush waits for it
  assign flushD = (pcsrcD | jumpD) & ~w_stall;

  // M-stage result is newer than W, so it takes priority
  assign fwdAE = (w_mHitRsE & r_ctrlM[0]) ? 2'b10 :
                 (w_wHitRsE & r_ctrlW[0]) ? 2'b01 : 2'b00;
  assign fwdBE = (w_mHitRtE & r_ctrlM[0]) ? 2'b10 :
                 (w_wHitRtE & r_ctrlW[0]) ? 2'b01 : 2'b00;
  assign fwdAD = w_mHitRsD & r_ctrlM[0];
  assign fwdBD = w_mHitRtD & r_ctrlM[0];

  assign ctrlE     = r_ctrlE;
  assign ctrlM     = r_ctrlM;
  assign ctrlW     = r_ctrlW;
  assign mdu_busy  = w_mduBusy;
  assign mdu_doneW = r_mduDone;

  // Control word pipeline; a stall injects a bubble into E
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrlE <= '0;
      r_ctrlM <= '0;
      r_ctrlW <= '0;
    end else begin
      r_ctrlE <= w_stall ? '0 : ctrlD;
      r_ctrlM <= r_ctrlE[2:0];
      r_ctrlW <= r_ctrlM[1:0];
    end
  end

  generate
    if (MDU_LAT > 0) begin : g_mduCnt
      logic [c_CNT_W-1:0] r_mduCnt;

      assign w_mduBusy = (r_mduCnt != '0);

      // Latency countdown; done fires the cycle after the last busy cycle
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_mduCnt  <= '0;
          r_mduDone <= 1'b0;
        end else begin
          if (w_mduAccept) begin
            r_mduCnt <= c_CNT_W'(MDU_LAT);
          end else if (r_mduCnt != '0) begin
            r_mduCnt <= r_mduCnt - 1'b1;
          end
          r_mduDone <= ~w_mduAccept & (r_mduCnt == c_CNT_W'(1));
        end
      end
    end else begin : g_mduComb
      assign w_mduBusy = 1'b0;

      // Single-cycle MDU: result is ready right after the accepted start
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_mduDone <= 1'b0;
        end else begin
          r_mduDone <= w_mduAccept;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
